// File: rtl/riscv_m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes, widths and
// the iterative FSM state encoding.
package riscv_m_pkg;

    localparam int RV_XLEN  = 32;
    localparam int RV_CNT_W = 6;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_iterative.sv
// Multi-cycle RV32M unit: radix-2 shift-add multiply and restoring divide on operand
// magnitudes, sharing one 33-bit adder, with a final sign-fix step.
module mdu_iterative
    import riscv_m_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int CNT_W = RV_CNT_W
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e          state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic [XLEN-1:0]     a_mag_q, a_mag_d;
    logic [XLEN-1:0]     b_mag_q, b_mag_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                a_signed, b_signed;
    logic                a_neg, b_neg;
    logic [XLEN-1:0]     a_mag_in, b_mag_in;
    logic [XLEN:0]       add_x, add_y;
    logic                add_cin;
    logic [XLEN+1:0]     add_sum;
    logic [2*XLEN-1:0]   mul_step, div_step;
    logic [2*XLEN-1:0]   prod_neg, mul_res;
    logic [XLEN-1:0]     quo, rem, fix_res;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op_i)
            MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            MDU_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        a_neg    = a_signed & src_a_i[XLEN-1];
        b_neg    = b_signed & src_b_i[XLEN-1];
        a_mag_in = a_neg ? -src_a_i : src_a_i;
        b_mag_in = b_neg ? -src_b_i : src_b_i;
    end

    // Divide feeds {rem, next dividend bit} minus divisor; carry-out means it fits.
    always_comb begin
        if (op_q[2]) begin
            add_x   = prod_q[2*XLEN-1:XLEN-1];
            add_y   = ~{1'b0, b_mag_q};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, prod_q[2*XLEN-1:XLEN]};
            add_y   = {1'b0, a_mag_q};
            add_cin = 1'b0;
        end
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, add_cin};

    always_comb begin
        mul_step = prod_q[0] ? {add_sum[XLEN:0], prod_q[XLEN-1:1]}
                             : {1'b0, prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1:1]};
        div_step = add_sum[XLEN+1] ? {add_sum[XLEN-1:0], prod_q[XLEN-2:0], 1'b1}
                                   : {prod_q[2*XLEN-2:0], 1'b0};
    end

    always_comb begin
        prod_neg = -prod_q;
        mul_res  = (sa_q ^ sb_q) ? prod_neg : prod_q;
        quo      = prod_q[XLEN-1:0];
        rem      = prod_q[2*XLEN-1:XLEN];
        case (op_q)
            MDU_MUL:                         fix_res = mul_res[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = mul_res[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               fix_res = (sa_q ^ sb_q) ? -quo : quo;
            default:                         fix_res = sa_q ? -rem : rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                // A start arriving while the previous done_o is still showing is dropped.
                if (start_i && !done_q) begin
                    op_d    = op_i;
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    a_mag_d = a_mag_in;
                    b_mag_d = b_mag_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    prod_d  = {{XLEN{1'b0}}, op_i[2] ? a_mag_in : b_mag_in};
                    if (op_i[2] && (src_b_i == '0)) begin
                        res_d   = op_i[1] ? src_a_i : '1;
                        state_d = ST_DONE;
                    end else if (((op_i == MDU_DIV) || (op_i == MDU_REM)) &&
                                 (src_a_i == INT_MIN) && (src_b_i == '1)) begin
                        res_d   = op_i[1] ? '0 : INT_MIN;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                prod_d = op_q[2] ? div_step : mul_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                res_d   = fix_res;
                state_d = ST_DONE;
            end
            default: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                result_d = res_q;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
